bcd_stopwatch: RTL and testbench

BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

---
 rtl/stopwatch_pkg.sv | 9 +
 rtl/bcd_digit.sv | 20 ++
 rtl/bcd_stopwatch.sv | 90 +++++++++
 tb/tb_bcd_stopwatch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, digit limits and BCD step helper
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, HALT = 2'd3} state_t;
  localparam logic [3:0] MAX10 = 4'd9;
  localparam logic [3:0] MAX6 = 4'd5;
  function automatic logic [3:0] bcd_step(input logic [3:0] q, input logic [3:0] mx);
    return (q == mx) ? 4'd0 : q + 4'd1;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one wrap-at-MAX BCD counter digit with synchronous clear
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = MAX10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       at_max
);
  assign at_max = (q == MAX);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= bcd_step(q, MAX);
  end
endmodule

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: push-button BCD stopwatch with prescaler, lap hold and overflow
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int                    NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS-1:0] MOD6_MASK  = NUM_DIGITS'(4'b1000),
  parameter int                    TICK_DIV   = 500000,
  parameter bit                    WRAP       = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    lap,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [4*NUM_DIGITS-1:0] disp,
  output logic                    running,
  output logic                    lap_hold,
  output logic                    overflow,
  output logic                    tick
);
  localparam int PW = $clog2(TICK_DIV);
  logic [2:0] r_s1, r_s2, r_s3;
  logic [2:0] w_ev;
  logic w_clr, w_ss, w_lap, w_run, w_full, w_hold_full;
  state_t r_state;
  logic [PW-1:0] r_pre;
  logic r_lap_hold, r_ovf;
  logic [4*NUM_DIGITS-1:0] r_snap, w_next;
  logic [NUM_DIGITS:0] w_carry;
  logic [NUM_DIGITS-1:0] w_at_max, w_inc;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= {clear, lap, start_stop};
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end
  assign w_ev  = r_s2 & ~r_s3;
  assign w_clr = w_ev[2];
  assign w_ss  = w_ev[0] & ~w_clr;
  assign w_lap = w_ev[1] & ~w_ev[0] & ~w_clr;
  assign w_run = (r_state == RUN);
  assign tick  = w_run && (r_pre == PW'(TICK_DIV - 1));
  assign w_carry[0] = tick;
  assign w_full = w_carry[NUM_DIGITS];
  // without wrap, a full-scale tick must leave every digit untouched
  assign w_hold_full = w_full & ~WRAP;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    localparam logic [3:0] MX = MOD6_MASK[g] ? MAX6 : MAX10;
    assign w_inc[g] = w_carry[g] & ~w_hold_full;
    assign w_carry[g+1] = w_carry[g] & w_at_max[g];
    assign w_next[4*g+:4] = w_inc[g] ? bcd_step(count[4*g+:4], MX) : count[4*g+:4];
    bcd_digit #(.MAX(MX)) u_digit (
      .clock (clock),
      .reset (reset),
      .clr   (w_clr),
      .inc   (w_inc[g]),
      .q     (count[4*g+:4]),
      .at_max(w_at_max[g])
    );
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset || w_clr) begin
      r_state    <= IDLE;
      r_pre      <= '0;
      r_lap_hold <= 1'b0;
      r_ovf      <= 1'b0;
      r_snap     <= '0;
    end else begin
      if (w_run) r_pre <= tick ? '0 : r_pre + 1'b1;
      if (w_full) r_ovf <= 1'b1;
      if (w_hold_full) r_state <= HALT;
      else if (w_ss && r_state != HALT) r_state <= (r_state == RUN) ? PAUSED : RUN;
      // the snapshot takes the post-update count so a same-edge tick is included
      if (w_lap && (r_state == RUN || r_state == PAUSED)) begin
        r_lap_hold <= ~r_lap_hold;
        if (!r_lap_hold) r_snap <= w_next;
      end
    end
  end
  assign running  = w_run;
  assign lap_hold = r_lap_hold;
  assign overflow = r_ovf;
  assign disp     = r_lap_hold ? r_snap : count;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: wrap and halt variants checked against an integer-count model
module tb_bcd_stopwatch;
  localparam int TD = 4;
  localparam int FULL = 5999;
  logic clock, reset, start_stop, lap, clear;
  logic [15:0] cnt[2], dsp[2];
  logic run[2], lh[2], ovf[2], tk[2];
  int errors = 0, checks = 0;
  int m_st[2], m_n[2], m_ph[2], m_snap[2];
  bit m_lh[2], m_ovf[2];
  int cd[3];
  bcd_stopwatch #(.TICK_DIV(TD), .WRAP(1'b1)) dut0 (
    .clock(clock), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .count(cnt[0]), .disp(dsp[0]), .running(run[0]), .lap_hold(lh[0]), .overflow(ovf[0]), .tick(tk[0])
  );
  bcd_stopwatch #(.TICK_DIV(TD), .WRAP(1'b0)) dut1 (
    .clock(clock), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .count(cnt[1]), .disp(dsp[1]), .running(run[1]), .lap_hold(lh[1]), .overflow(ovf[1]), .tick(tk[1])
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic logic [15:0] bcd(input int n);
    return {4'(n / 1000 % 6), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_rst();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_n[k] = 0; m_ph[k] = 0; m_snap[k] = 0; m_lh[k] = 0; m_ovf[k] = 0;
    end
    for (int b = 0; b < 3; b++) cd[b] = 0;
  endtask
  // one rising edge of the stopwatch seen as run-cycles, ticks and integer counts
  task automatic model_edge();
    bit e[3];
    for (int b = 0; b < 3; b++) begin
      e[b] = (cd[b] == 1);
      if (cd[b] > 0) cd[b]--;
    end
    for (int k = 0; k < 2; k++) begin
      int os;
      bit t;
      if (e[2]) begin
        m_st[k] = 0; m_n[k] = 0; m_ph[k] = 0; m_lh[k] = 0; m_ovf[k] = 0;
      end else begin
        os = m_st[k];
        t = (os == 1) && (m_ph[k] == TD - 1);
        if (os == 1) m_ph[k] = (m_ph[k] + 1) % TD;
        if (t && m_n[k] == FULL) begin
          m_ovf[k] = 1;
          if (k == 0) m_n[k] = 0;
          else m_st[k] = 3;
        end else if (t) m_n[k]++;
        if (e[0] && m_st[k] != 3) m_st[k] = (os == 1) ? 2 : 1;
        if (e[1] && !e[0] && (os == 1 || os == 2)) begin
          m_lh[k] = !m_lh[k];
          if (m_lh[k]) m_snap[k] = m_n[k];
        end
      end
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("count%0d", k), cnt[k], bcd(m_n[k]));
      chk($sformatf("disp%0d", k), dsp[k], m_lh[k] ? bcd(m_snap[k]) : bcd(m_n[k]));
      chk($sformatf("running%0d", k), run[k], m_st[k] == 1);
      chk($sformatf("lap_hold%0d", k), lh[k], m_lh[k]);
      chk($sformatf("overflow%0d", k), ovf[k], m_ovf[k]);
      chk($sformatf("tick%0d", k), tk[k], m_st[k] == 1 && m_ph[k] == TD - 1);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask
  task automatic press_raw(input logic [2:0] m);
    {clear, lap, start_stop} = m;
    for (int b = 0; b < 3; b++) if (m[b]) cd[b] = 3;
  endtask
  task automatic release_all();
    {clear, lap, start_stop} = 3'b000;
  endtask
  task automatic press(input logic [2:0] m);
    press_raw(m);
    cyc(); cyc();
    release_all();
    cyc(); cyc(); cyc();
  endtask
  task automatic run_until(input int target, input int limit);
    for (int i = 0; i < limit && m_n[0] != target; i++) cyc();
    chk($sformatf("reach_%0d", target), cnt[0], bcd(target));
  endtask
  initial begin
    int nb;
    reset = 1'b1;
    release_all();
    model_rst();
    repeat (3) @(negedge clock);
    check_all();
    reset = 1'b0;
    // start and count to ten
    press_raw(3'b001);
    cyc(); cyc();
    chk("pre_run", run[0], 1'b0);
    release_all();
    cyc();
    chk("start_run0", run[0], 1'b1);
    chk("start_run1", run[1], 1'b1);
    repeat (40) cyc();
    chk("ten_cnt0", cnt[0], 16'h0010);
    chk("ten_cnt1", cnt[1], 16'h0010);
    // lap freeze at 42
    run_until(42, 200);
    press(3'b010);
    chk("lap_set", lh[0], 1'b1);
    chk("lap_disp", dsp[0], 16'h0042);
    chk("lap_cnt", cnt[0], 16'h0043);
    repeat (20) cyc();
    chk("lap_frozen", dsp[0], 16'h0042);
    chk("lap_live", cnt[0], 16'h0048);
    press(3'b010);
    chk("lap_clr", lh[0], 1'b0);
    chk("lap_track", dsp[0], bcd(m_n[0]));
    // pause with prescaler at 2, resume
    for (int i = 0; i < 8 && m_ph[0] != 3; i++) cyc();
    press(3'b001);
    chk("pause_run", run[0], 1'b0);
    repeat (100) cyc();
    nb = m_n[0];
    press_raw(3'b001);
    cyc(); cyc();
    release_all();
    cyc();
    chk("resume_run", run[0], 1'b1);
    chk("resume_t0", tk[0], 1'b0);
    cyc();
    chk("resume_t1", tk[0], 1'b1);
    chk("resume_c1", cnt[0], bcd(nb));
    cyc();
    chk("resume_c2", cnt[0], bcd(nb + 1));
    // random button activity
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 10) repeat ($urandom_range(1, 30)) cyc();
      else if (r < 14) press(3'b001);
      else if (r < 18) press(3'b010);
      else if (r == 18) press(3'b100);
      else press(3'b011);
    end
    // carry into the thousands digit
    press(3'b100);
    press(3'b001);
    run_until(959, 5000);
    run_until(1000, 200);
    chk("carry_cnt", cnt[0], 16'h1000);
    chk("carry_ovf", ovf[0], 1'b0);
    // full scale: wrap vs halt
    run_until(FULL, 21000);
    for (int i = 0; i < 8 && m_n[0] != 0; i++) cyc();
    chk("wrap_cnt", cnt[0], 16'h0000);
    chk("wrap_ovf", ovf[0], 1'b1);
    chk("wrap_run", run[0], 1'b1);
    chk("halt_cnt", cnt[1], 16'h5999);
    chk("halt_ovf", ovf[1], 1'b1);
    chk("halt_run", run[1], 1'b0);
    press(3'b001);
    chk("halt_ss_run", run[1], 1'b0);
    chk("halt_ss_cnt", cnt[1], 16'h5999);
    chk("wrap_pause", run[0], 1'b0);
    // clear beats start_stop
    press(3'b100);
    press(3'b001);
    press(3'b010);
    chk("pre_clr_lh", lh[0], 1'b1);
    press(3'b101);
    chk("clr_run", run[0], 1'b0);
    chk("clr_cnt", cnt[0], 16'h0000);
    chk("clr_lh", lh[0], 1'b0);
    chk("clr_ovf1", ovf[1], 1'b0);
    // asynchronous reset between edges
    press(3'b001);
    repeat (10) cyc();
    #2;
    reset = 1'b1;
    model_rst();
    #1;
    check_all();
    chk("async_cnt", cnt[0], 16'h0000);
    @(posedge clock);
    @(negedge clock);
    check_all();
    reset = 1'b0;
    press_raw(3'b001);
    cyc(); cyc();
    release_all();
    cyc();
    chk("post_rst_run", run[0], 1'b1);
    repeat (10) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
